// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with bypass, busy scoreboard and re-init sweep
module reg_file_param #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg_read_addr_1,
  output logic [DATA_W-1:0] reg_read_data_1,
  input  logic [ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              reg_busy_1,
  output logic              reg_busy_2,
  input  logic              init_req,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              init_busy_q, init_busy_d;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic wr_fire, wr_ok, rsv_ok, hit_1, hit_2;

  assign wr_fire = reg_write_en & ~init_busy_q;
  assign wr_ok   = wr_fire & ~is_zero(reg_write_dest);
  assign rsv_ok  = rsv_en & ~init_busy_q & ~is_zero(rsv_addr);

  // Forwarding only applies to writes that will actually land this edge.
  assign hit_1 = (BYPASS != 0) && wr_fire && (reg_write_dest == reg_read_addr_1);
  assign hit_2 = (BYPASS != 0) && wr_fire && (reg_write_dest == reg_read_addr_2);

  assign reg_read_data_1 = is_zero(reg_read_addr_1) ? '0 :
                           hit_1 ? reg_write_data : mem_q[reg_read_addr_1];
  assign reg_read_data_2 = is_zero(reg_read_addr_2) ? '0 :
                           hit_2 ? reg_write_data : mem_q[reg_read_addr_2];
  assign reg_busy_1 = ~is_zero(reg_read_addr_1) & busy_q[reg_read_addr_1] & ~hit_1;
  assign reg_busy_2 = ~is_zero(reg_read_addr_2) & busy_q[reg_read_addr_2] & ~hit_2;
  assign init_busy  = init_busy_q;

  always_comb begin
    mem_d       = mem_q;
    busy_d      = busy_q;
    state_d     = state_q;
    idx_d       = idx_q;
    init_busy_d = init_busy_q;
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          mem_d[reg_write_dest]  = reg_write_data;
          busy_d[reg_write_dest] = 1'b0;
        end
        // Reserve is applied after the write so a new producer wins on the same address.
        if (rsv_ok) busy_d[rsv_addr] = 1'b1;
        if (init_req) begin
          state_d     = SWEEP;
          idx_d       = '0;
          init_busy_d = 1'b1;
        end
      end
      SWEEP: begin
        mem_d[idx_q]  = DATA_W'(idx_q);
        busy_d[idx_q] = 1'b0;
        idx_d         = idx_q + ADDR_W'(1);
        if (&idx_q) begin
          state_d     = IDLE;
          init_busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(i);
      busy_q      <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      init_busy_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_busy_q <= init_busy_d;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - randomized model-checked bench for two reg_file_param configurations
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_we, a_rsv, a_init, a_b1, a_b2, a_ib;
  logic [3:0] a_dest, a_wd, a_ra1, a_ra2, a_rsva, a_rd1, a_rd2;
  logic       b_we, b_rsv, b_init, b_b1, b_b2, b_ib;
  logic [4:0] b_dest, b_ra1, b_ra2, b_rsva;
  logic [7:0] b_wd, b_rd1, b_rd2;

  reg_file_param u_dut_a (
    .clk(clk), .rst(rst),
    .reg_write_en(a_we), .reg_write_dest(a_dest), .reg_write_data(a_wd),
    .reg_read_addr_1(a_ra1), .reg_read_data_1(a_rd1),
    .reg_read_addr_2(a_ra2), .reg_read_data_2(a_rd2),
    .rsv_en(a_rsv), .rsv_addr(a_rsva),
    .reg_busy_1(a_b1), .reg_busy_2(a_b2),
    .init_req(a_init), .init_busy(a_ib)
  );

  reg_file_param #(.DATA_W(8), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .reg_write_en(b_we), .reg_write_dest(b_dest), .reg_write_data(b_wd),
    .reg_read_addr_1(b_ra1), .reg_read_data_1(b_rd1),
    .reg_read_addr_2(b_ra2), .reg_read_data_2(b_rd2),
    .rsv_en(b_rsv), .rsv_addr(b_rsva),
    .reg_busy_1(b_b1), .reg_busy_2(b_b2),
    .init_req(b_init), .init_busy(b_ib)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = 4x16 with bypass, index 1 = 8x32 without bypass.
  int depth [2] = '{16, 32};
  int dmask [2] = '{15, 255};
  bit byp   [2] = '{1'b1, 1'b0};
  int mem   [2][32];
  bit bsy   [2][32];
  bit swp   [2];
  int cnt   [2];

  int we [2], dest [2], wd [2], ra1 [2], ra2 [2], rsv [2], rsva [2], ireq [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        mem[k][i] = i & dmask[k];
        bsy[k][i] = 1'b0;
      end
      swp[k] = 1'b0;
      cnt[k] = 0;
    end
  endfunction

  function automatic bit fwd(int k, int addr);
    return byp[k] && we[k] != 0 && !swp[k] && dest[k] == addr;
  endfunction

  function automatic int exp_rd(int k, int addr);
    if (addr == 0) return 0;
    if (fwd(k, addr)) return wd[k];
    return mem[k][addr];
  endfunction

  function automatic int exp_busy(int k, int addr);
    if (addr == 0) return 0;
    return (bsy[k][addr] && !fwd(k, addr)) ? 1 : 0;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (swp[k]) begin
        mem[k][cnt[k]] = cnt[k] & dmask[k];
        bsy[k][cnt[k]] = 1'b0;
        cnt[k]++;
        if (cnt[k] == depth[k]) begin
          swp[k] = 1'b0;
          cnt[k] = 0;
        end
      end else begin
        if (we[k] != 0 && dest[k] != 0) begin
          mem[k][dest[k]] = wd[k];
          bsy[k][dest[k]] = 1'b0;
        end
        if (rsv[k] != 0 && rsva[k] != 0) bsy[k][rsva[k]] = 1'b1;
        if (ireq[k] != 0) begin
          swp[k] = 1'b1;
          cnt[k] = 0;
        end
      end
    end
  endfunction

  function automatic void idle_stim();
    for (int k = 0; k < 2; k++) begin
      we[k] = 0; dest[k] = 0; wd[k] = 0; ra1[k] = 0; ra2[k] = 0;
      rsv[k] = 0; rsva[k] = 0; ireq[k] = 0;
    end
  endfunction

  function automatic void rand_stim();
    for (int k = 0; k < 2; k++) begin
      we[k]   = $urandom_range(0, 1);
      dest[k] = $urandom_range(0, depth[k] - 1);
      wd[k]   = $urandom & dmask[k];
      ra1[k]  = $urandom_range(0, 1) ? dest[k] : $urandom_range(0, depth[k] - 1);
      rsv[k]  = $urandom_range(0, 2) == 0 ? 1 : 0;
      rsva[k] = $urandom_range(0, 1) ? dest[k] : $urandom_range(0, depth[k] - 1);
      ra2[k]  = $urandom_range(0, 1) ? rsva[k] : $urandom_range(0, depth[k] - 1);
      ireq[k] = $urandom_range(0, 59) == 0 ? 1 : 0;
    end
  endfunction

  task automatic drive();
    a_we = we[0][0]; a_dest = 4'(dest[0]); a_wd = 4'(wd[0]);
    a_ra1 = 4'(ra1[0]); a_ra2 = 4'(ra2[0]);
    a_rsv = rsv[0][0]; a_rsva = 4'(rsva[0]); a_init = ireq[0][0];
    b_we = we[1][0]; b_dest = 5'(dest[1]); b_wd = 8'(wd[1]);
    b_ra1 = 5'(ra1[1]); b_ra2 = 5'(ra2[1]);
    b_rsv = rsv[1][0]; b_rsva = 5'(rsva[1]); b_init = ireq[1][0];
  endtask

  task automatic check_outputs();
    check_eq("a_rd1", a_rd1, exp_rd(0, ra1[0]));
    check_eq("a_rd2", a_rd2, exp_rd(0, ra2[0]));
    check_eq("a_busy1", a_b1, exp_busy(0, ra1[0]));
    check_eq("a_busy2", a_b2, exp_busy(0, ra2[0]));
    check_eq("a_init_busy", a_ib, swp[0]);
    check_eq("b_rd1", b_rd1, exp_rd(1, ra1[1]));
    check_eq("b_rd2", b_rd2, exp_rd(1, ra2[1]));
    check_eq("b_busy1", b_b1, exp_busy(1, ra1[1]));
    check_eq("b_busy2", b_b2, exp_busy(1, ra2[1]));
    check_eq("b_init_busy", b_ib, swp[1]);
  endtask

  // Inputs are applied just after a rising edge and outputs sampled on the falling edge.
  task automatic step();
    drive();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_both(input int w, input int d, input int dat, input int r1,
                          input int r2, input int rs, input int rsad, input int ir);
    for (int k = 0; k < 2; k++) begin
      we[k] = w; dest[k] = d; wd[k] = dat; ra1[k] = r1; ra2[k] = r2;
      rsv[k] = rs; rsva[k] = rsad; ireq[k] = ir;
    end
  endtask

  int a_cnt, b_cnt;

  initial begin
    idle_stim();
    drive();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset contents on every address of both instances.
    for (int i = 0; i < 32; i++) begin
      idle_stim();
      for (int k = 0; k < 2; k++) begin
        ra1[k] = i % depth[k];
        ra2[k] = (depth[k] - 1 - i) % depth[k];
      end
      step();
    end

    // Bypass: write 0xA to reg 5 read same cycle, then next cycle; write to reg 0 ignored.
    set_both(1, 5, 10, 5, 5, 0, 0, 0); step();
    set_both(0, 0, 0, 5, 0, 0, 0, 0);  step();
    set_both(1, 0, 15, 0, 0, 0, 0, 0); step();
    set_both(0, 0, 0, 0, 5, 0, 0, 0);  step();

    // Scoreboard: reserve reg 3, write clears it, same-cycle reserve+write leaves it busy.
    set_both(0, 0, 0, 0, 3, 1, 3, 0);  step();
    set_both(0, 0, 0, 3, 3, 0, 0, 0);  step();
    set_both(1, 3, 7, 3, 3, 0, 0, 0);  step();
    set_both(0, 0, 0, 3, 3, 0, 0, 0);  step();
    set_both(1, 3, 7, 3, 3, 1, 3, 0);  step();
    set_both(0, 0, 0, 3, 3, 0, 0, 0);  step();
    set_both(0, 0, 0, 0, 0, 1, 0, 0);  step();
    set_both(0, 0, 0, 0, 0, 0, 0, 0);  step();

    // Sweep: write reg 9, start sweep, writes to reg 4 dropped, mid-sweep init_req ignored.
    set_both(1, 9, 2, 9, 9, 1, 6, 0);  step();
    set_both(0, 0, 0, 9, 6, 0, 0, 1);  step();
    a_cnt = a_ib ? 1 : 0;
    b_cnt = b_ib ? 1 : 0;
    for (int c = 0; c < 40; c++) begin
      set_both(c < 14 ? 1 : 0, 4, 12, 4, 9, c < 14 ? 1 : 0, 6, (c == 5) ? 1 : 0);
      step();
      if (a_ib) a_cnt++;
      if (b_ib) b_cnt++;
    end
    check_eq("a_sweep_len", a_cnt, 16);
    check_eq("b_sweep_len", b_cnt, 32);
    for (int i = 0; i < 32; i++) begin
      idle_stim();
      for (int k = 0; k < 2; k++) begin
        ra1[k] = i % depth[k];
        ra2[k] = (i + 7) % depth[k];
      end
      step();
    end

    // Asynchronous reset partway through a sweep.
    for (int c = 0; c < 12; c++) begin
      rand_stim();
      step();
    end
    set_both(0, 0, 0, 0, 0, 0, 0, 1); step();
    for (int c = 0; c < 6; c++) begin
      set_both(1, 7, 1, 7, 2, 0, 0, 0); step();
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("a_init_busy_rst", a_ib, 0);
    check_eq("b_init_busy_rst", b_ib, 0);
    for (int i = 0; i < 32; i++) begin
      idle_stim();
      for (int k = 0; k < 2; k++) begin
        ra1[k] = i % depth[k];
        ra2[k] = (i + 1) % depth[k];
      end
      drive();
      #1;
      check_outputs();
    end
    idle_stim();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic including occasional sweeps.
    for (int c = 0; c < 2000; c++) begin
      rand_stim();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised register file for the MIPS datapath: configurable data width and depth, two combinational read ports and one write port. Adds optional write-to-read bypass, a per-register busy scoreboard for pipeline hazard detection, and a command-driven re-initialisation sweep that restores every register to its index value without asserting reset. Sits between decode (read/reserve) and writeback (write) in the processor.

## Interface

Parameters:
- DATA_W, 4, register width in bits (>=1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers (derived, not overridable)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- ZERO_REG, 1, 1 = register 0 hardwired to zero (reads 0, writes and reservations ignored)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- reg_write_en  in  1  write strobe
- reg_write_dest  in  ADDR_W  write address
- reg_write_data  in  DATA_W  write data
- reg_read_addr_1  in  ADDR_W  read port 1 address
- reg_read_data_1  out  DATA_W  read port 1 data (combinational)
- reg_read_addr_2  in  ADDR_W  read port 2 address
- reg_read_data_2  out  DATA_W  read port 2 data (combinational)
- rsv_en  in  1  reserve strobe: mark rsv_addr busy (producer issued)
- rsv_addr  in  ADDR_W  register to reserve
- reg_busy_1  out  1  busy status of reg_read_addr_1 (combinational)
- reg_busy_2  out  1  busy status of reg_read_addr_2 (combinational)
- init_req  in  1  start re-initialisation sweep (single-cycle pulse or level)
- init_busy  out  1  sweep in progress; registered

## Operation

- Reset (asynchronous): reg[i] = i mod 2**DATA_W for all i; all busy bits 0; FSM IDLE; sweep index 0; init_busy 0. Read data outputs then reflect reset contents (addr 0 reads 0 when ZERO_REG=1).
- Write: accepted at rising edge when reg_write_en=1 and init_busy=0; reg[dest] <= data, busy[dest] <= 0. Dropped while init_busy=1.
- Reserve: accepted at rising edge when rsv_en=1 and init_busy=0; busy[rsv_addr] <= 1. Dropped while init_busy=1.
- Reserve and write to same address in the same cycle: data written AND busy bit set (new producer wins). Different addresses: both take effect.
- ZERO_REG=1: writes and reservations to address 0 are ignored; busy[0] always 0.
- Read port n data: ZERO_REG=1 and addr=0 -> 0; else BYPASS=1 and accepted write (reg_write_en & ~init_busy) with dest=addr -> reg_write_data; else reg[addr].
- reg_busy_n: busy[addr] & ~(BYPASS=1 and accepted write hit on addr); 0 for addr 0 when ZERO_REG=1. Both ports independent; same address on both ports gives identical results.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when init_req=1 at edge; sweep index <= 0; init_busy <= 1. A write/reserve in that same cycle is still accepted (init_busy was 0) and later overwritten by the sweep.
  - SWEEP: each edge writes reg[idx] <= idx mod 2**DATA_W, busy[idx] <= 0, idx <= idx+1. Edge writing idx = DEPTH-1: -> IDLE, init_busy <= 0, idx wraps to 0.
  - init_req during SWEEP ignored (no restart, no extension).
  - Reads during SWEEP return current array contents (mix of old and reinitialised), no bypass.
- rst asserted mid-sweep: immediate full reset values, FSM IDLE.

## Timing

- Write latency: 1 edge to array; 0 cycles visible on read ports when BYPASS=1.
- Reserve latency: busy visible on reg_busy_n the cycle after the accepting edge.
- init_req sampled at edge k: init_busy high from after edge k until after edge k+DEPTH (exactly DEPTH cycles); registers 0..DEPTH-1 rewritten at edges k+1..k+DEPTH; first external write accepted at edge k+DEPTH+1.
- Read paths and busy outputs purely combinational from addresses, array, busy bits and write inputs; no registered read latency.

## Test plan

- Reset then read all 16 addresses (defaults) -> data = index, addr 0 -> 0; busy all 0; init_busy 0.
- Write 4'hA to reg 5 with BYPASS=1, read_addr_1=5 same cycle -> reg_read_data_1=4'hA same cycle; BYPASS=0 -> 4'h5 that cycle, 4'hA next; write 4'hF to reg 0 -> reads 0.
- rsv_en on reg 3, next cycle read_addr_2=3 -> reg_busy_2=1; write reg 3 = 4'h7 -> reg_busy_2=0 in same cycle (BYPASS=1); same-cycle rsv+write reg 3 -> data 4'h7 and busy=1 afterwards.
- Write reg 9 = 4'h2, pulse init_req -> init_busy high exactly 16 cycles; write reg 4 = 4'hC during sweep dropped; after sweep reg 9 = 9, reg 4 = 4, all busy 0; init_req mid-sweep does not extend.
- Assert rst at sweep cycle 6 -> init_busy 0 immediately, all registers = index, FSM IDLE.
- DATA_W=8, ADDR_W=5 instance -> reset reg 31 = 8'd31; write/read and 32-cycle sweep behave as above.
